// File: rtl/cnn_mem_arbiter.sv
// Memory-port arbiter and program loader: shares one single-port synchronous RAM
// between a valid/ready loader stream and the CPU request/mem_ready port.
module cnn_mem_arbiter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned AUTO_INC = 1
) (
    input  logic              clkn,
    input  logic              rstn,
    input  logic              sel_in,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W:0]   ld_count,
    output logic              busy_load,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned LDCNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, CPU_ACC, CPU_WAIT, LOAD} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                wr_pend, wr_pend_n;
    logic                first_beat, first_beat_n;
    logic [ADDR_W-1:0]   ptr, ptr_n;
    logic [ADDR_W-1:0]   beat_addr;
    logic                hs;
    logic [ADDR_W:0]     ld_count_n;
    logic [DATA_W-1:0]   cpu_rdata_n;
    logic                mem_ready_n;
    logic                busy_load_n;
    logic                ram_we_n;
    logic [ADDR_W-1:0]   ram_addr_n;
    logic [DATA_W-1:0]   ram_wdata_n;

    assign ld_ready  = (state == LOAD) && sel_in;
    assign hs        = ld_valid && ld_ready;
    assign beat_addr = ((AUTO_INC == 0) || first_beat) ? ld_addr : ptr;

    // Next-state and next-register values; a completed write holds IDLE for one
    // cycle so the delayed mem_ready pulse cannot be overtaken by a new request.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        wr_pend_n    = 1'b0;
        first_beat_n = first_beat;
        ptr_n        = ptr;
        ld_count_n   = ld_count;
        cpu_rdata_n  = cpu_rdata;
        mem_ready_n  = wr_pend;
        ram_we_n     = 1'b0;
        ram_addr_n   = ram_addr;
        ram_wdata_n  = ram_wdata;
        case (state)
            IDLE: begin
                if (wr_pend) begin
                    state_n = IDLE;
                end else if (sel_in) begin
                    state_n      = LOAD;
                    ld_count_n   = '0;
                    first_beat_n = 1'b1;
                end else if (cpu_req) begin
                    state_n     = CPU_ACC;
                    ram_we_n    = cpu_we;
                    ram_addr_n  = cpu_addr;
                    ram_wdata_n = cpu_wdata;
                end
            end
            CPU_ACC: begin
                if (ram_we) begin
                    state_n   = IDLE;
                    wr_pend_n = 1'b1;
                end else begin
                    state_n = CPU_WAIT;
                    cnt_n   = '0;
                end
            end
            CPU_WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_n     = IDLE;
                    cpu_rdata_n = ram_rdata;
                    mem_ready_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            LOAD: begin
                if (!sel_in) begin
                    state_n = IDLE;
                end else if (hs) begin
                    ram_we_n     = 1'b1;
                    ram_wdata_n  = ld_data;
                    ram_addr_n   = beat_addr;
                    ptr_n        = beat_addr + ADDR_W'(1);
                    first_beat_n = 1'b0;
                    if (!ld_count[ADDR_W]) begin
                        ld_count_n = ld_count + LDCNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        busy_load_n = (state_n == LOAD);
    end

    always_ff @(posedge clkn or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_pend    <= 1'b0;
            first_beat <= 1'b0;
            ptr        <= '0;
            ld_count   <= '0;
            cpu_rdata  <= '0;
            mem_ready  <= 1'b0;
            busy_load  <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            wr_pend    <= wr_pend_n;
            first_beat <= first_beat_n;
            ptr        <= ptr_n;
            ld_count   <= ld_count_n;
            cpu_rdata  <= cpu_rdata_n;
            mem_ready  <= mem_ready_n;
            busy_load  <= busy_load_n;
            ram_we     <= ram_we_n;
            ram_addr   <= ram_addr_n;
            ram_wdata  <= ram_wdata_n;
        end
    end

endmodule

// File: tb/tb_cnn_mem_arbiter.sv
// Directed bench for cnn_mem_arbiter: RD_LAT=2 instances with AUTO_INC=1 and
// AUTO_INC=0 driven in parallel, plus a behavioural RAM on the AUTO_INC=1 one.
module tb_cnn_mem_arbiter;

    logic        clkn;
    logic        rstn;
    logic        sel_in;
    logic        ld_valid;
    logic [11:0] ld_addr;
    logic [15:0] ld_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_wdata;

    logic        ld_ready, busy_load, mem_ready, ram_we;
    logic [12:0] ld_count;
    logic [15:0] cpu_rdata, ram_wdata, ram_rdata;
    logic [11:0] ram_addr;

    logic        na_ld_ready, na_busy_load, na_mem_ready, na_ram_we;
    logic [12:0] na_ld_count;
    logic [15:0] na_cpu_rdata, na_ram_wdata;
    logic [11:0] na_ram_addr;

    int checks = 0;
    int errors = 0;

    cnn_mem_arbiter #(.DATA_W(16), .ADDR_W(12), .RD_LAT(2), .AUTO_INC(1)) dut (
        .clkn(clkn), .rstn(rstn), .sel_in(sel_in),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_count(ld_count), .busy_load(busy_load),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .mem_ready(mem_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    cnn_mem_arbiter #(.DATA_W(16), .ADDR_W(12), .RD_LAT(2), .AUTO_INC(0)) dut_na (
        .clkn(clkn), .rstn(rstn), .sel_in(sel_in),
        .ld_valid(ld_valid), .ld_ready(na_ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_count(na_ld_count), .busy_load(na_busy_load),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(na_cpu_rdata), .mem_ready(na_mem_ready),
        .ram_we(na_ram_we), .ram_addr(na_ram_addr), .ram_wdata(na_ram_wdata),
        .ram_rdata(16'h0000)
    );

    // Synchronous RAM with two cycles of read latency.
    logic [15:0] mem [0:4095];
    logic [15:0] rd1, rd2;
    always @(posedge clkn) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rd1 <= mem[ram_addr];
        rd2 <= rd1;
    end
    assign ram_rdata = rd2;

    initial clkn = 1'b0;
    always #5 clkn = ~clkn;

    task automatic cyc();
        @(posedge clkn);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; sel_in = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #3;
        checks++;
        if ({ld_ready, busy_load, mem_ready, ram_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {ld_ready, busy_load, mem_ready, ram_we});
        end
        checks++;
        if ({ld_count, ram_addr} !== 25'h0) begin
            errors++;
            $display("FAIL reset_cnt_addr got %h/%h exp 0/0", ld_count, ram_addr);
        end
        checks++;
        if ({cpu_rdata, ram_wdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h exp 0/0", cpu_rdata, ram_wdata);
        end
        #9 rstn = 1'b1;
    endtask

    task automatic test_auto_load();
        cyc();
        sel_in = 1'b1;
        cyc();
        checks++;
        if (busy_load !== 1'b1) begin
            errors++; $display("FAIL load_busy got %b exp 1", busy_load);
        end
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++; $display("FAIL load_ready got %b exp 1", ld_ready);
        end
        ld_valid = 1'b1; ld_addr = 12'h010; ld_data = 16'hA001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if ({ram_we, mem_ready, ram_addr, ram_wdata} !==
                {1'b1, 1'b0, 12'h010 + 12'(i), 16'hA001 + 16'(i)}) begin
                errors++;
                $display("FAIL load_beat%0d got we=%b rdy=%b a=%h d=%h exp we=1 rdy=0 a=%h d=%h",
                         i, ram_we, mem_ready, ram_addr, ram_wdata,
                         12'h010 + 12'(i), 16'hA001 + 16'(i));
            end
            if (i < 3) ld_data = 16'hA002 + 16'(i);
            else ld_valid = 1'b0;
        end
        cyc();
        checks++;
        if ({ram_we, ld_count} !== {1'b0, 13'd4}) begin
            errors++; $display("FAIL load_end got we=%b cnt=%0d exp we=0 cnt=4", ram_we, ld_count);
        end
        sel_in = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin
            errors++; $display("FAIL load_drop_ready got %b exp 0", ld_ready);
        end
        cyc();
        checks++;
        if ({busy_load, ld_count} !== {1'b0, 13'd4}) begin
            errors++; $display("FAIL load_exit got busy=%b cnt=%0d exp busy=0 cnt=4", busy_load, ld_count);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] exp_a [3];
        exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000;
        sel_in = 1'b1;
        cyc();
        ld_valid = 1'b1; ld_addr = 12'hFFE;
        for (int i = 0; i < 3; i++) begin
            ld_data = 16'hC000 + 16'(i);
            cyc();
            checks++;
            if ({ram_addr, na_ram_addr, na_ram_we} !== {exp_a[i], 12'hFFE, 1'b1}) begin
                errors++;
                $display("FAIL wrap_beat%0d got a=%h na=%h exp a=%h na=ffe", i, ram_addr, na_ram_addr, exp_a[i]);
            end
        end
        ld_valid = 1'b0; sel_in = 1'b0;
        cyc();
        sel_in = 1'b1;
        cyc();
        checks++;
        if (ld_count !== 13'd0) begin
            errors++; $display("FAIL reentry_count got %0d exp 0", ld_count);
        end
        ld_valid = 1'b1; ld_addr = 12'h055;
        for (int i = 0; i < 3; i++) begin
            ld_data = 16'hD000 + 16'(i);
            cyc();
            checks++;
            if ({na_ram_addr, ram_addr} !== {12'h055, 12'h055 + 12'(i)}) begin
                errors++;
                $display("FAIL fixed_beat%0d got na=%h a=%h exp na=055 a=%h", i, na_ram_addr, ram_addr, 12'h055 + 12'(i));
            end
        end
        ld_valid = 1'b0; sel_in = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_cpu_read();
        sel_in = 1'b1;
        cyc();
        ld_valid = 1'b1; ld_addr = 12'h020; ld_data = 16'h1234;
        cyc();
        ld_valid = 1'b0; sel_in = 1'b0;
        cyc();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
        cyc();
        checks++;
        if ({mem_ready, ram_we, ram_addr} !== {1'b0, 1'b0, 12'h020}) begin
            errors++; $display("FAIL rd_issue got rdy=%b we=%b a=%h exp 0 0 020", mem_ready, ram_we, ram_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            cyc();
            checks++;
            if (mem_ready !== (k == 3)) begin
                errors++; $display("FAIL rd_ready_e0p%0d got %b exp %b", k, mem_ready, k == 3);
            end
        end
        checks++;
        if (cpu_rdata !== 16'h1234) begin
            errors++; $display("FAIL rd_data got %h exp 1234", cpu_rdata);
        end
        cpu_req = 1'b0;
        cyc();
        checks++;
        if ({mem_ready, cpu_rdata} !== {1'b0, 16'h1234}) begin
            errors++; $display("FAIL rd_after got rdy=%b d=%h exp 0 1234", mem_ready, cpu_rdata);
        end
    endtask

    task automatic test_cpu_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h030; cpu_wdata = 16'hBEEF;
        cyc();
        checks++;
        if ({ram_we, mem_ready, ram_addr, ram_wdata} !== {1'b1, 1'b0, 12'h030, 16'hBEEF}) begin
            errors++;
            $display("FAIL wr_issue got we=%b rdy=%b a=%h d=%h exp 1 0 030 beef", ram_we, mem_ready, ram_addr, ram_wdata);
        end
        cyc();
        checks++;
        if ({ram_we, mem_ready} !== 2'b00) begin
            errors++; $display("FAIL wr_e0p1 got we=%b rdy=%b exp 0 0", ram_we, mem_ready);
        end
        cyc();
        checks++;
        if ({ram_we, mem_ready} !== 2'b01) begin
            errors++; $display("FAIL wr_e0p2 got we=%b rdy=%b exp 0 1", ram_we, mem_ready);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        cyc();
        checks++;
        if ({ram_we, mem_ready} !== 2'b00) begin
            errors++; $display("FAIL wr_e0p3 got we=%b rdy=%b exp 0 0", ram_we, mem_ready);
        end
    endtask

    task automatic test_contention_start();
        bit seen = 1'b0;
        sel_in = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h011;
        cyc();
        checks++;
        if ({busy_load, ram_we, mem_ready} !== 3'b100) begin
            errors++; $display("FAIL cont_load_first got %b exp 100", {busy_load, ram_we, mem_ready});
        end
        cyc();
        checks++;
        if ({busy_load, ram_we, mem_ready} !== 3'b100) begin
            errors++; $display("FAIL cont_load_hold got %b exp 100", {busy_load, ram_we, mem_ready});
        end
        sel_in = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin
            errors++; $display("FAIL cont_ready_drop got %b exp 0", ld_ready);
        end
        cyc();
        checks++;
        if ({busy_load, mem_ready} !== 2'b00) begin
            errors++; $display("FAIL cont_idle got %b exp 00", {busy_load, mem_ready});
        end
        cyc();
        checks++;
        if (ram_addr !== 12'h011) begin
            errors++; $display("FAIL cont_cpu_addr got %h exp 011", ram_addr);
        end
        for (int k = 0; k < 8 && !seen; k++) begin
            cyc();
            if (mem_ready) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL cont_timeout got no mem_ready exp pulse");
        end
        checks++;
        if (cpu_rdata !== 16'hA002) begin
            errors++; $display("FAIL cont_rdata got %h exp a002", cpu_rdata);
        end
        cpu_req = 1'b0;
        cyc();
    endtask

    task automatic test_contention_read();
        int hit = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h030;
        cyc();
        sel_in = 1'b1;
        for (int k = 0; k < 8 && hit < 0; k++) begin
            cyc();
            if (mem_ready) begin
                hit = k;
                cpu_req = 1'b0;
            end else begin
                #1;
                checks++;
                if ({ld_ready, busy_load} !== 2'b00) begin
                    errors++; $display("FAIL mid_read_ready k%0d got %b exp 00", k, {ld_ready, busy_load});
                end
            end
        end
        checks++;
        if (hit !== 2) begin
            errors++; $display("FAIL mid_read_latency got %0d exp 2", hit);
        end
        checks++;
        if (cpu_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL mid_read_data got %h exp beef", cpu_rdata);
        end
        cyc();
        #1;
        checks++;
        if ({busy_load, ld_ready, mem_ready} !== 3'b110) begin
            errors++; $display("FAIL mid_read_load got %b exp 110", {busy_load, ld_ready, mem_ready});
        end
        sel_in = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset_mid_load();
        sel_in = 1'b1;
        cyc();
        ld_valid = 1'b1; ld_addr = 12'h040; ld_data = 16'h5555;
        cyc();
        checks++;
        if (ram_we !== 1'b1) begin
            errors++; $display("FAIL rst_pre_we got %b exp 1", ram_we);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({ram_we, ld_ready, mem_ready, busy_load} !== 4'b0000) begin
            errors++; $display("FAIL rst_async got %b exp 0000", {ram_we, ld_ready, mem_ready, busy_load});
        end
        checks++;
        if (cpu_rdata !== 16'h0000) begin
            errors++; $display("FAIL rst_rdata got %h exp 0000", cpu_rdata);
        end
        sel_in = 1'b0; ld_valid = 1'b0;
        @(negedge clkn);
        rstn = 1'b1;
        cyc();
        checks++;
        if ({busy_load, ram_we, ld_count} !== {1'b0, 1'b0, 13'd0}) begin
            errors++; $display("FAIL rst_release got busy=%b we=%b cnt=%0d exp 0 0 0", busy_load, ram_we, ld_count);
        end
    endtask

    initial begin
        test_reset();
        test_auto_load();
        test_wrap();
        test_cpu_read();
        test_cpu_write();
        test_contention_start();
        test_contention_read();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnn_mem_arbiter.md
Name: cnn_mem_arbiter

Overview:
- Parametrised memory-port arbiter and program loader for the 16-bit CNN CPU.
- Shares one single-port synchronous RAM between:
  - an external loader stream, with a valid/ready handshake and optional auto-increment addressing;
  - the CPU's request/mem_ready port.
- Replaces plain sel_in muxing: in-flight CPU accesses complete cleanly, the CPU stalls during loads, and RAM read latency is configurable.

Parameters:
DATA_W, 16, data width of loader, CPU and RAM paths
ADDR_W, 12, address width
RD_LAT, 1, RAM read latency in cycles (>=1)
AUTO_INC, 1, 1: loader address taken from ld_addr on first beat, then internal pointer +1 per beat; 0: ld_addr used every beat

Ports:
clkn  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
sel_in  in  1  1 = loader owns RAM
ld_valid  in  1  loader beat valid
ld_ready  out  1  loader beat accepted when ld_valid&&ld_ready
ld_addr  in  ADDR_W  loader address
ld_data  in  DATA_W  loader data
ld_count  out  ADDR_W+1  beats written since LOAD entry
busy_load  out  1  high in LOAD
cpu_req  in  1  CPU access request (level)
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data, valid while mem_ready=1
mem_ready  out  1  one-cycle access-complete pulse
ram_we  out  1  RAM write enable (registered)
ram_addr  out  ADDR_W  RAM address (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_addr

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE.
  - All outputs 0: ld_ready, ld_count, busy_load, cpu_rdata, mem_ready, ram_we, ram_addr, ram_wdata.
  - Any in-flight write or read is aborted; ram_we drops immediately.
- States: IDLE, CPU_ACC, CPU_WAIT, LOAD.
- IDLE:
  - sel_in=1 -> LOAD, even if cpu_req=1 in the same cycle (loader wins).
  - Else cpu_req=1 -> CPU_ACC. cpu_we, cpu_addr and cpu_wdata are registered into ram_we, ram_addr and ram_wdata on that edge (e0).
- CPU_ACC (one cycle):
  - ram_we=cpu_we is presented this cycle; ram_we clears at the next edge.
  - Write -> IDLE, with mem_ready=1 for the cycle starting at e0+2.
  - Read -> CPU_WAIT.
- CPU_WAIT:
  - A counter waits RD_LAT-1 further cycles.
  - ram_rdata is captured into cpu_rdata; mem_ready=1 for the cycle starting at e0+RD_LAT+1; state -> IDLE.
  - cpu_rdata holds its value until the next read completes.
- The CPU deasserts cpu_req on mem_ready. If cpu_req is still high in IDLE, a new access starts.
- sel_in is ignored outside IDLE. A CPU access in flight always completes before LOAD is entered.
- LOAD:
  - busy_load=1; ld_ready = sel_in (combinational, state==LOAD). mem_ready=0 throughout.
  - Handshake cycle: the next edge registers ram_we=1, ram_wdata=ld_data and ram_addr.
    - ram_addr = ld_addr if AUTO_INC=0 or this is the first beat; otherwise the pointer.
    - pointer = ram_addr+1, wrapping modulo 2^ADDR_W.
    - ld_count increments, saturating at 2^ADDR_W.
  - No handshake -> ram_we=0 next cycle.
  - Throughput is one beat per cycle.
  - ld_count and the first-beat flag clear on LOAD entry.
- sel_in=0 while in LOAD:
  - ld_ready=0 that cycle; state -> IDLE at the next edge.
  - A write registered from the last handshake still appears in the first IDLE cycle.
  - A CPU access may begin at that same edge; its ram_* registration occurs one edge later, so there is no overlap.
- ld_count holds after exiting LOAD until the next LOAD entry.

Test Plan:
- Reset mid-load: rstn=0 while ram_we=1 -> ram_we, ld_ready, mem_ready, busy_load =0 immediately; after release state IDLE and ld_count=0.
- Auto-increment load (AUTO_INC=1): sel_in=1, ld_addr=0x010, 4 back-to-back beats 0xA001..0xA004 -> ram writes at 0x010..0x013 with matching data on consecutive cycles, ld_count=4, mem_ready never 1.
- Wrap: AUTO_INC=1, start 0xFFE, 3 beats -> ram_addr 0xFFE, 0xFFF, 0x000. AUTO_INC=0 with ld_addr=0x055 held -> all beats write to 0x055.
- CPU read, RD_LAT=2: RAM[0x020]=0x1234; cpu_req read 0x020 sampled at e0 -> mem_ready=1 exactly in the cycle from e0+3, cpu_rdata=0x1234.
- CPU write: cpu_we=1, addr 0x030, data 0xBEEF at e0 -> ram_we=1 for one cycle from e0, mem_ready=1 in the cycle from e0+2.
- Contention:
  - sel_in and cpu_req rise together in IDLE -> LOAD first; cpu_req is serviced only after sel_in falls.
  - sel_in rises during a CPU read -> the read returns correct data, and ld_ready stays 0 until mem_ready has pulsed.
